int_to_float: RTL and testbench

Sequential IEEE-754 single-precision converter from 32-bit integer (signed or unsigned) to float, rounding per RISC-V `rm` and reporting `fflags`. It is the FPU's `fcvt.s.w`/`fcvt.s.wu` stage and the counterpart of the float-to-int converter. It takes operands from the FPU operand latch and delivers results to the FPU result mux through strobe/ack handshakes on both sides.

---
 rtl/fpu_pkg.sv | 48 ++++
 rtl/int_to_float_lzc32.sv | 16 +
 rtl/int_to_float.sv | 136 +++++++++++++
 tb/tb_int_to_float.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, fflags bit positions,
// the single-precision exponent bias and the converter state encoding.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [7:0] FP32_BIAS = 8'd127;

    typedef enum logic [2:0] {
        GET_A,
        SPECIAL,
        NORMALISE,
        ROUND,
        PUT_Z
    } state_t;

    // Increment decision for a truncated mantissa, given guard/round/sticky.
    // Reserved encodings fall back to round-to-nearest-even.
    function automatic logic round_up(
        input logic [2:0] mode,
        input logic       sign,
        input logic       lsb,
        input logic       guard,
        input logic       round_bit,
        input logic       sticky
    );
        logic inexact;
        inexact = guard | round_bit | sticky;
        case (mode)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & inexact;
            RM_RUP:  round_up = ~sign & inexact;
            RM_RMM:  round_up = guard;
            default: round_up = guard & (round_bit | sticky | lsb);
        endcase
    endfunction

endpackage

// File: rtl/int_to_float_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
// Used by int_to_float only when INT_TO_FLOAT_FAST_NORM_EN is defined.
module lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    always_comb begin
        count = 6'd32;
        // Scanning upward lets the most significant set bit win.
        for (int i = 0; i < 32; i++) begin
            if (value[i]) count = 6'(31 - i);
        end
    end

endmodule

// File: rtl/int_to_float.sv
// Sequential int32/uint32 -> IEEE-754 single converter with RISC-V rounding.
// Define INT_TO_FLOAT_FAST_NORM_EN to normalise in one cycle via lzc32.
module int_to_float
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_unsigned,
    input  logic [2:0]  rm,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack,
    output logic [4:0]  flag
);

    state_t      state;
    logic [31:0] a;
    logic [2:0]  rm_q;
    logic        is_unsigned;
    logic        sign;
    logic [31:0] m;
    logic [7:0]  e;

    logic        operand_sign;
    logic [31:0] operand_mag;

    logic        guard;
    logic        round_bit;
    logic        sticky;
    logic        increment;
    logic [23:0] frac_inc;
    logic [7:0]  exp_unbiased;
    logic [31:0] result;
    logic [4:0]  flag_next;

    assign input_a_ack  = (state == GET_A) && !rst;
    assign output_z_stb = (state == PUT_Z);

    // Two's-complement negate leaves 0x80000000 unchanged, which is exactly
    // the magnitude of INT_MIN when read as unsigned.
    assign operand_sign = !is_unsigned && a[31];
    assign operand_mag  = operand_sign ? (~a + 32'd1) : a;

`ifdef INT_TO_FLOAT_FAST_NORM_EN
    logic [5:0] lz;

    lzc32 u_lzc (
        .value (m),
        .count (lz)
    );
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        guard     = m[7];
        round_bit = m[6];
        sticky    = |m[5:0];
        increment = round_up(rm_q, sign, m[8], guard, round_bit, sticky);
        // The leading one is implicit, so a carry out of the 23-bit fraction
        // is the 24-bit mantissa overflow that bumps the exponent.
        frac_inc     = {1'b0, m[30:8]} + {23'd0, increment};
        exp_unbiased = e + {7'd0, frac_inc[23]};
        result       = {sign, exp_unbiased + FP32_BIAS, frac_inc[22:0]};
        flag_next          = '0;
        flag_next[FLAG_NX] = guard | round_bit | sticky;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // The operand/datapath registers are not reset: each is written before
    // it is read in every conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= GET_A;
            output_z <= '0;
            flag     <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (input_a_stb) begin
                        a           <= input_a;
                        rm_q        <= rm;
                        is_unsigned <= input_unsigned;
                        state       <= SPECIAL;
                    end
                end

                SPECIAL: begin
                    sign <= operand_sign;
                    m    <= operand_mag;
                    e    <= 8'd31;
                    if (operand_mag == '0) begin
                        output_z <= '0;
                        flag     <= '0;
                        state    <= PUT_Z;
                    end else begin
                        state <= NORMALISE;
                    end
                end

                NORMALISE: begin
`ifdef INT_TO_FLOAT_FAST_NORM_EN
                    // m is nonzero here, so lz never exceeds 31.
                    m     <= m << lz;
                    e     <= e - {2'b00, lz};
                    state <= ROUND;
`else
                    if (!m[31]) begin
                        m <= m << 1;
                        e <= e - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
`endif
                end

                ROUND: begin
                    output_z <= result;
                    flag     <= flag_next;
                    state    <= PUT_Z;
                end

                PUT_Z: begin
                    if (output_z_ack) state <= GET_A;
                end

                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed corner cases, randomized
// operands against an arithmetic reference model, handshake and reset checks.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a;
    logic        input_unsigned;
    logic [2:0]  rm;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    logic [4:0]  flag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_to_float dut (
        .clk            (clk),
        .rst            (rst),
        .input_a        (input_a),
        .input_unsigned (input_unsigned),
        .rm             (rm),
        .input_a_stb    (input_a_stb),
        .input_a_ack    (input_a_ack),
        .output_z       (output_z),
        .output_z_stb   (output_z_stb),
        .output_z_ack   (output_z_ack),
        .flag           (flag)
    );

    // Reference: exact integer value, scaled to 24 significant bits, with the
    // discarded remainder compared against half an ulp to decide rounding.
    function automatic logic [32:0] ref_conv(input logic [31:0] a, input logic uns,
                                             input logic [2:0] mode, output int lz);
        longint unsigned mag, q, rem, half;
        int   p;
        logic s, nx, inc;
        logic [7:0] ex;
        s   = !uns && a[31];
        mag = s ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        lz  = 32;
        if (mag == 0) return 33'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        lz = 31 - p;
        if (p <= 23) begin
            q = mag << (23 - p); rem = 0; half = 1;
        end else begin
            q = mag >> (p - 23); rem = mag - (q << (p - 23)); half = 64'd1 << (p - 24);
        end
        nx = (rem != 0);
        case (mode)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && nx;
            3'd3:    inc = !s && nx;
            3'd4:    inc = nx && (rem >= half);
            default: inc = (rem > half) || (nx && rem == half && q[0]);
        endcase
        q = q + {63'd0, inc};
        if (q == 64'h100_0000) begin
            q = 64'h80_0000;
            p = p + 1;
        end
        ex = 8'(p + 127);
        return {nx, s, ex, q[22:0]};
    endfunction

    function automatic int ref_latency(input int lz);
        if (lz == 32) return 1;
`ifdef INT_TO_FLOAT_FAST_NORM_EN
        return 3;
`else
        return lz + 3;
`endif
    endfunction

    // Drives one operand and waits (bounded) for the result strobe.
    // With noise set, input_a_stb and output_z_ack toggle randomly while busy.
    task automatic issue_and_wait(input logic [31:0] a, input logic uns, input logic [2:0] mode,
                                  input bit noise, output logic [31:0] z, output logic [4:0] fl,
                                  output int lat, output bit to);
        int w;
        to = 1'b0; z = 'x; fl = 'x; lat = 0;
        w = 0;
        while (!input_a_ack && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!input_a_ack) begin
            to = 1'b1;
            return;
        end
        input_a = a; input_unsigned = uns; rm = mode; input_a_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
        input_a = $urandom; rm = 3'($urandom); input_unsigned = 1'($urandom);
        while (!output_z_stb && lat < 60) begin
            if (noise) begin
                input_a_stb  = 1'($urandom);
                output_z_ack = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        input_a_stb  = 1'b0;
        output_z_ack = 1'b0;
        if (!output_z_stb) to = 1'b1;
        z  = output_z;
        fl = flag;
    endtask

    task automatic consume();
        output_z_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_z_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; input_a_stb = 1'b0; output_z_ack = 1'b0;
        input_a = '0; input_unsigned = 1'b0; rm = 3'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (input_a_ack !== 1'b0) begin
            n_err++; $display("FAIL reset_ack_during_rst: got %b expected 0", input_a_ack);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({output_z_stb, output_z, flag, input_a_ack} !== {1'b0, 32'd0, 5'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got stb=%b z=%h flag=%b ack=%b expected stb=0 z=0 flag=0 ack=1",
                     output_z_stb, output_z, flag, input_a_ack);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [12] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                 32'h80000000, 32'h01000001, 32'h01000001, 32'h01000001,
                                 32'hFEFFFFFF, 32'h0, 32'h01000003};
        logic        vu [12] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        logic [2:0]  vr [12] = '{0, 0, 0, 1, 0, 0, 0, 3, 4, 2, 0, 6};
        logic [31:0] vz [12] = '{32'h3F800000, 32'hBF800000, 32'h4F800000, 32'h4F7FFFFF,
                                 32'hCF000000, 32'h4F000000, 32'h4B800000, 32'h4B800001,
                                 32'h4B800001, 32'hCB800001, 32'h00000000, 32'h4B800002};
        logic        vx [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1};
        logic [31:0] z;
        logic [4:0]  fl;
        logic [32:0] unused_ref;
        int lat, lz;
        bit to;
        for (int i = 0; i < 12; i++) begin
            issue_and_wait(va[i], vu[i], vr[i], 1'b0, z, fl, lat, to);
            unused_ref = ref_conv(va[i], vu[i], vr[i], lz);
            n_cmp++;
            if (to) begin
                n_err++; $display("FAIL directed_%0d_timeout: no strobe within bound", i);
            end else begin
                if (z !== vz[i]) begin
                    n_err++; $display("FAIL directed_%0d_z: got %h expected %h", i, z, vz[i]);
                end
                n_cmp++;
                if (fl !== {4'd0, vx[i]}) begin
                    n_err++; $display("FAIL directed_%0d_flag: got %b expected %b", i, fl, {4'd0, vx[i]});
                end
                n_cmp++;
                if (lat != ref_latency(lz)) begin
                    n_err++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, ref_latency(lz));
                end
                consume();
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, z;
        logic [32:0] exp_r;
        logic [4:0]  fl;
        logic        uns;
        logic [2:0]  mode;
        int lat, lz;
        bit to;
        for (int i = 0; i < 200; i++) begin
            a    = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = ~a;
            uns  = 1'($urandom);
            mode = 3'($urandom_range(0, 7));
            exp_r = ref_conv(a, uns, mode, lz);
            issue_and_wait(a, uns, mode, 1'b1, z, fl, lat, to);
            n_cmp++;
            if (to) begin
                n_err++; $display("FAIL random_timeout: a=%h no strobe within bound", a);
                return;
            end
            if ({fl, z} !== {4'd0, exp_r} || lat != ref_latency(lz)) begin
                n_err++;
                $display("FAIL random_conv: a=%h uns=%b rm=%0d got z=%h flag=%b lat=%0d expected z=%h flag=%b lat=%0d",
                         a, uns, mode, z, fl, lat, exp_r[31:0], {4'd0, exp_r[32]}, ref_latency(lz));
            end
            consume();
        end
    endtask

    task automatic test_hold();
        logic [31:0] z;
        logic [4:0]  fl;
        int lat;
        bit to;
        issue_and_wait(32'h0, 1'b0, 3'd3, 1'b0, z, fl, lat, to);
        n_cmp++;
        if (to || z !== 32'h0 || fl !== 5'd0 || lat != 1) begin
            n_err++; $display("FAIL hold_zero: got z=%h flag=%b lat=%0d to=%b expected z=0 flag=0 lat=1",
                              z, fl, lat, to);
        end
        input_a_stb = 1'b1;
        input_a = 32'h7;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({output_z_stb, input_a_ack, output_z, flag} !== {1'b1, 1'b0, 32'h0, 5'd0}) begin
                n_err++;
                $display("FAIL hold_cycle_%0d: got stb=%b ack=%b z=%h flag=%b expected stb=1 ack=0 z=0 flag=0",
                         c, output_z_stb, input_a_ack, output_z, flag);
            end
        end
        input_a_stb = 1'b0;
        consume();
        n_cmp++;
        if ({output_z_stb, input_a_ack, output_z} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++; $display("FAIL hold_release: got stb=%b ack=%b z=%h expected stb=0 ack=1 z=0",
                              output_z_stb, input_a_ack, output_z);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [4] = '{32'h00000400, 32'hFFFFFC00, 32'h7FFFFFFF, 32'h00FFFFFF};
        logic [31:0] z;
        logic [32:0] exp_r;
        logic [4:0]  fl;
        int lat, lz;
        bit to;
        for (int i = 0; i < 4; i++) begin
            exp_r = ref_conv(ops[i], 1'b0, 3'd0, lz);
            issue_and_wait(ops[i], 1'b0, 3'd0, 1'b0, z, fl, lat, to);
            n_cmp++;
            if (to || {fl, z} !== {4'd0, exp_r}) begin
                n_err++; $display("FAIL b2b_%0d_conv: got z=%h flag=%b to=%b expected z=%h flag=%b",
                                  i, z, fl, to, exp_r[31:0], {4'd0, exp_r[32]});
            end
            if (to) return;
            consume();
            n_cmp++;
            if ({input_a_ack, output_z_stb} !== 2'b10) begin
                n_err++; $display("FAIL b2b_%0d_handshake: got ack=%b stb=%b expected ack=1 stb=0",
                                  i, input_a_ack, output_z_stb);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] z;
        logic [32:0] exp_r;
        logic [4:0]  fl;
        int lat, lz, seen;
        bit to;
        issue_and_wait(32'h00012345, 1'b1, 3'd0, 1'b0, z, fl, lat, to);
        if (!to) consume();
        input_a = 32'h1; input_unsigned = 1'b0; rm = 3'd0; input_a_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({output_z_stb, output_z, flag} !== {1'b0, 32'h0, 5'd0}) begin
            n_err++; $display("FAIL midreset_state: got stb=%b z=%h flag=%b expected stb=0 z=0 flag=0",
                              output_z_stb, output_z, flag);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (output_z_stb || !input_a_ack) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL midreset_idle: got %0d busy/strobe cycles expected 0", seen);
        end
        exp_r = ref_conv(32'hFFFFFF01, 1'b0, 3'd1, lz);
        issue_and_wait(32'hFFFFFF01, 1'b0, 3'd1, 1'b0, z, fl, lat, to);
        n_cmp++;
        if (to || {fl, z} !== {4'd0, exp_r} || lat != ref_latency(lz)) begin
            n_err++; $display("FAIL midreset_fresh: got z=%h flag=%b lat=%0d expected z=%h flag=%b lat=%0d",
                              z, fl, lat, exp_r[31:0], {4'd0, exp_r[32]}, ref_latency(lz));
        end
        if (!to) consume();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
